// File: rtl/lsu_writeback.sv
// lsu_writeback: multi-cycle load/store unit, writer side of the register file.
//
// Accepts one memory op at a time from execute (op_valid/op_ready), drives a
// request/grant/response data-memory bus, aligns and sign/zero-extends load data,
// and issues a single-cycle register-file write (wb_we/wb_rd_addr/wb_wdata).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op_*                  memory op from execute; op_ready high only in IDLE
//   mem_req/we/addr/be/wdata, mem_gnt, mem_rvalid, mem_rdata
//                         data-memory bus (word-aligned address, lane byte enables)
//   wb_we, wb_rd_addr, wb_wdata   register-file write port
//   done                  one-cycle pulse when an op retires
//   bus_err               one-cycle pulse when an op is aborted by the timeout
//   misalign_err          (LSU_MISALIGN_TRAP_EN only) pulse after a misaligned op
//
// Parameters:
//   TIMEOUT  cycles allowed in REQ plus RSP before abort; 0 disables the timeout
//   CNT_W    timeout counter width; must hold TIMEOUT
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of silently dropping the low address bits.
module lsu_writeback #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_is_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_wdata,
  output logic        done,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StWb} state_e;

  state_e state_q, state_d;

  logic [31:0]      addr_q;
  logic [2:0]       funct3_q;
  logic             is_store_q;
  logic [31:0]      wdata_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, bus_err_q, wb_we_q;
  logic [4:0]       wb_rd_addr_q;
  logic [31:0]      wb_wdata_q;

  logic        start;
  logic        expire;
  logic        size_b, size_h;
  logic [1:0]  off;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic op_misaligned;
  logic misalign_q;

  always_comb begin
    unique case (op_funct3[1:0])
      2'b00:   op_misaligned = 1'b0;
      2'b01:   op_misaligned = op_addr[0];
      default: op_misaligned = (op_addr[1:0] != 2'b00);
    endcase
  end

  assign start = op_valid & ~op_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state_q == StIdle) & op_valid & op_misaligned;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign start = op_valid;
`endif

  // Counter value on the last allowed cycle; a grant/response that same cycle wins.
  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. unsupported codes) word.
  assign size_b = (funct3_q[1:0] == 2'b00);
  assign size_h = (funct3_q[1:0] == 2'b01);
  assign off    = addr_q[1:0];

  always_comb begin
    st_be   = 4'hF;
    st_data = wdata_q;
    if (size_b) begin
      st_be   = 4'b0001 << off;
      st_data = {4{wdata_q[7:0]}};
    end else if (size_h) begin
      st_be   = 4'b0011 << {off[1], 1'b0};
      st_data = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    ld_byte = 8'(mem_rdata >> {off, 3'b000});
    ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] selects zero extension (BU/HU).
    if (size_b) begin
      ld_data = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
    end else if (size_h) begin
      ld_data = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
    end else begin
      ld_data = mem_rdata;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StReq;
      StReq: begin
        if (mem_gnt)     state_d = is_store_q ? StIdle : StRsp;
        else if (expire) state_d = StIdle;
      end
      StRsp: begin
        if (mem_rvalid)  state_d = StWb;
        else if (expire) state_d = StIdle;
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus-side outputs
  always_comb begin
    op_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: op_ready = 1'b1;
      StReq: begin
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = st_be;
        mem_wdata = is_store_q ? st_data : '0;
      end
      default: ;
    endcase
  end

  // Op latch, timeout counter and registered writeback/status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      wdata_q      <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_wdata_q   <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        addr_q     <= op_addr;
        funct3_q   <= op_funct3;
        is_store_q <= op_is_store;
        wdata_q    <= op_wdata;
        rd_q       <= op_rd;
        cnt_q      <= '0;
      end else if (state_q == StReq || state_q == StRsp) begin
        cnt_q <= cnt_q + 1'b1;
      end

      done_q    <= (state_q == StReq && mem_gnt && is_store_q) ||
                   (state_q == StRsp && mem_rvalid);
      bus_err_q <= (state_q == StReq && !mem_gnt && expire) ||
                   (state_q == StRsp && !mem_rvalid && expire);
      wb_we_q   <= (state_q == StRsp) && mem_rvalid && (rd_q != 5'd0);

      if (state_q == StRsp && mem_rvalid) begin
        wb_rd_addr_q <= rd_q;
        // x0 writes are suppressed, so the data bus keeps its previous value.
        if (rd_q != 5'd0) wb_wdata_q <= ld_data;
      end
    end
  end

  assign done       = done_q;
  assign bus_err    = bus_err_q;
  assign wb_we      = wb_we_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_wdata   = wb_wdata_q;

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Multi-cycle load/store unit that produces the register-file write port (we / rd address / write data), the writer side of the register file.
- Accepts one memory op at a time from execute and drives a request/grant/response data-memory bus.
- Aligns and sign/zero-extends load data and issues a single-cycle register write.
- Stalls the front end via op_ready while an op is outstanding.

Parameters:
- TIMEOUT, 256, cycles allowed in REQ plus RSP before abort; 0 disables the timeout.
- CNT_W, 9, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  execute presents a memory op
- op_ready  out  1  unit can accept an op
- op_is_store  in  1  1=store, 0=load
- op_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- op_addr  in  32  effective byte address
- op_wdata  in  32  store data (rs2)
- op_rd  in  5  load destination register
- mem_req  out  1  bus request
- mem_we  out  1  store request
- mem_addr  out  32  word-aligned address {op_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  load response valid
- mem_rdata  in  32  load response word
- wb_we  out  1  register-file write enable
- wb_rd_addr  out  5  register-file write address
- wb_wdata  out  32  register-file write data
- done  out  1  one-cycle pulse when an op retires
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: clk and async active-low rst_n (rst_n low clears immediately).
  - State returns to IDLE.
  - op_ready=1; mem_req, mem_we, mem_be, mem_wdata, mem_addr, wb_we, wb_rd_addr, wb_wdata, done, bus_err all 0.
  - Reset mid-op discards the op; any later mem_gnt/mem_rvalid is ignored.
- FSM states: IDLE, REQ, RSP, WB.
  - IDLE: op_ready=1. On op_valid, latch all op_* fields, clear the timeout counter, go to REQ.
  - REQ: mem_req=1; addr/we/be/wdata stable until mem_gnt.
    - Store granted: done=1 next cycle, return to IDLE.
    - Load granted: go to RSP.
  - RSP: wait for mem_rvalid, capture and extract data, go to WB.
  - WB: one cycle with wb_we=1 only if latched rd!=0; wb_rd_addr=rd; done=1; return to IDLE.
  - op_ready=0 in every state except IDLE.
- Store lane rules, with off=op_addr[1:0]:
  - SB: be=4'b0001<<off; wdata = byte replicated x4.
  - SH: be=4'b0011<<{off[1],1'b0}; wdata = half replicated x2.
  - SW: be=4'hF.
- Load extraction: select byte at off or half at off[1] from mem_rdata. B/H sign-extend, BU/HU zero-extend, W passes through.
- Unsupported funct3 (011, 110, 111): treated as W.
- mem_rvalid outside RSP and mem_gnt outside REQ are ignored.
- Timeout (TIMEOUT>0): counter increments each cycle in REQ/RSP.
  - Reaching TIMEOUT: bus_err pulse, no writeback, no done, return to IDLE.
  - Grant/response arriving on the expiry cycle wins over the abort.
- Minimum latency:
  - Load: accept at cycle 0, REQ at cycle 1 (gnt same cycle), RSP at cycle 2 (rvalid), WB/done at cycle 3.
  - Store: done at cycle 2.
- wb_wdata holds its last value while wb_we=0.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned ops (H with addr[0]=1; W with addr[1:0]!=0) are detected in IDLE on accept.
  - Adds output misalign_err (1 bit, reset 0), pulsed the cycle after accept.
  - No bus request, no writeback, no done; unit stays/returns to IDLE.
- Undefined:
  - Port absent.
  - Misaligned low bits are ignored: H uses off[1]; W is forced aligned. Access proceeds normally.

Test Plan:
- LW addr 0x100, rd=5, gnt immediate, rvalid next cycle with 0xDEADBEEF -> wb_we=1, wb_rd_addr=5, wb_wdata=0xDEADBEEF at cycle 3, done same cycle.
- LB addr 0x103, rdata 0x80FF_0000 -> wb_wdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, wdata 0x12345678 -> mem_be=4'b0010, mem_wdata=0x78787878, mem_addr=0x200; SH addr 0x202 -> be=4'b1100, mem_wdata=0x56785678.
- mem_gnt delayed 5 cycles -> mem_req and mem_addr stable throughout, op_ready=0, single done; load with rd=0 -> wb_we stays 0, done=1.
- TIMEOUT=4, no gnt -> bus_err pulse after 4 REQ cycles, no wb_we; rst_n low in RSP, then late rvalid -> no writeback, op_ready=1.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x102 -> misalign_err pulse, mem_req never asserted; without the macro -> mem_addr=0x100, be=4'hF, normal writeback.
